// File: rtl/r2sdf_stage_64.sv
// Radix-2 single-path delay-feedback butterfly stage: DEPTH-deep complex delay line, add/sub butterfly, twiddle multiply.
// Optional build macro SDF_SCALE_EN: halve butterfly sum/difference (floor) so the stage never overflows.
module r2sdf_stage_64 #(
  parameter int DW      = 24,
  parameter int DEPTH   = 64,
  parameter int TW_FRAC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [23:0]   w_r,
  input  logic [23:0]   w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_BFLY    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ILLEGAL = 2'd3
  } phase_t;

  localparam int PW = DW + 24;
  localparam logic signed [PW:0] RND = (PW + 1)'(1) << (TW_FRAC - 1);

  logic [DW-1:0] r_dl_r [DEPTH];
  logic [DW-1:0] r_dl_i [DEPTH];
  logic          r_out_valid;
  logic [DW-1:0] r_dout_r;
  logic [DW-1:0] r_dout_i;
  logic          r_err;

  phase_t               w_phase;
  logic signed [DW-1:0] w_h_r, w_h_i, w_x_r, w_x_i;
  logic signed [23:0]   w_wr, w_wi;
  logic signed [DW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic [DW-1:0]        w_bf_sum_r, w_bf_sum_i, w_bf_dif_r, w_bf_dif_i;
  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [PW:0]   w_pr_rnd, w_pi_rnd;
  logic [DW-1:0]        w_mul_r, w_mul_i;
  logic [DW-1:0]        w_push_r, w_push_i;
  logic                 w_unused;

  assign w_phase = phase_t'(state);
  assign w_h_r   = $signed(r_dl_r[DEPTH-1]);
  assign w_h_i   = $signed(r_dl_i[DEPTH-1]);
  assign w_x_r   = $signed(din_r);
  assign w_x_i   = $signed(din_i);
  assign w_wr    = $signed(w_r);
  assign w_wi    = $signed(w_i);

  // One guard bit so the sum/difference is exact before wrap or scaling.
  assign w_sum_r = (DW + 1)'(w_h_r) + (DW + 1)'(w_x_r);
  assign w_sum_i = (DW + 1)'(w_h_i) + (DW + 1)'(w_x_i);
  assign w_dif_r = (DW + 1)'(w_h_r) - (DW + 1)'(w_x_r);
  assign w_dif_i = (DW + 1)'(w_h_i) - (DW + 1)'(w_x_i);

`ifdef SDF_SCALE_EN
  assign w_bf_sum_r = w_sum_r[DW:1];
  assign w_bf_sum_i = w_sum_i[DW:1];
  assign w_bf_dif_r = w_dif_r[DW:1];
  assign w_bf_dif_i = w_dif_i[DW:1];
`else
  assign w_bf_sum_r = w_sum_r[DW-1:0];
  assign w_bf_sum_i = w_sum_i[DW-1:0];
  assign w_bf_dif_r = w_dif_r[DW-1:0];
  assign w_bf_dif_i = w_dif_i[DW-1:0];
`endif

  assign w_p_rr = PW'(w_h_r) * PW'(w_wr);
  assign w_p_ii = PW'(w_h_i) * PW'(w_wi);
  assign w_p_ri = PW'(w_h_r) * PW'(w_wi);
  assign w_p_ir = PW'(w_h_i) * PW'(w_wr);

  assign w_pr_rnd = (PW + 1)'(w_p_rr) - (PW + 1)'(w_p_ii) + RND;
  assign w_pi_rnd = (PW + 1)'(w_p_ri) + (PW + 1)'(w_p_ir) + RND;

  // Taking bits above TW_FRAC equals an arithmetic shift followed by wrap to DW.
  assign w_mul_r = w_pr_rnd[TW_FRAC +: DW];
  assign w_mul_i = w_pi_rnd[TW_FRAC +: DW];

  assign w_unused = ^{w_sum_r, w_sum_i, w_dif_r, w_dif_i, w_pr_rnd, w_pi_rnd};

  always_comb begin
    w_push_r = din_r;
    w_push_i = din_i;
    if (w_phase == ST_BFLY) begin
      w_push_r = w_bf_dif_r;
      w_push_i = w_bf_dif_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_dl_r[k] <= '0;
        r_dl_i[k] <= '0;
      end
    end else if (in_valid) begin
      r_dl_r[0] <= w_push_r;
      r_dl_i[0] <= w_push_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_dl_r[k] <= r_dl_r[k-1];
        r_dl_i[k] <= r_dl_i[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dout_r    <= '0;
      r_dout_i    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= in_valid && ((w_phase == ST_BFLY) || (w_phase == ST_DRAIN));
      if (in_valid) begin
        case (w_phase)
          ST_BFLY: begin
            r_dout_r <= w_bf_sum_r;
            r_dout_i <= w_bf_sum_i;
          end
          ST_DRAIN: begin
            r_dout_r <= w_mul_r;
            r_dout_i <= w_mul_i;
          end
          ST_ILLEGAL: r_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout_r    = r_dout_r;
  assign dout_i    = r_dout_i;
  assign err       = r_err;

endmodule

// File: tb/tb_r2sdf_stage_64.sv
// Bench for r2sdf_stage_64: FIFO-model scoreboard over whole blocks, plus a table of single-butterfly vectors.
module tb_r2sdf_stage_64;
  localparam int DW    = 24;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] din_r, din_i;
  logic [1:0]    state;
  logic [23:0]   w_r, w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r, dout_i;
  logic          err;

  r2sdf_stage_64 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i), .out_valid(out_valid),
    .dout_r(dout_r), .dout_i(dout_i), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } exp_t;

  typedef struct {
    logic [1:0] st;
    int hr, hi, xr, xi, wr, wi, er, ei;
  } vec_t;

  exp_t                 exp_q[$];
  logic signed [DW-1:0] m_r[$];
  logic signed [DW-1:0] m_i[$];
  bit                   m_err;
  int                   n_total = 0;
  int                   n_pass  = 0;
  vec_t                 tbl[7];

  function automatic logic [DW-1:0] bf(input longint s);
`ifdef SDF_SCALE_EN
    s = s >>> 1;
`endif
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] rnd(input longint p);
    return DW'((p + 128) >>> 8);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_r.delete(); m_i.delete(); exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      m_r.push_back('0);
      m_i.push_back('0);
    end
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; state = 2'd1;
    din_r = DW'(12345); din_i = DW'(-77);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout_r", $signed(dout_r), 0);
    chk("rst_dout_i", $signed(dout_i), 0);
    chk("rst_err", err, 0);
    $display("reset: out_valid=%0d dout=(%0d,%0d) err=%0d", out_valid, $signed(dout_r), $signed(dout_i), err);
  endtask

  task automatic adv(input bit v, input logic [1:0] st, input int xr, input int xi,
                     input int wr, input int wi);
    exp_t e;
    logic signed [DW-1:0] hr, hi, pr, pi, xr_t, xi_t;
    logic signed [23:0] wr_t, wi_t;
    xr_t = DW'(xr); xi_t = DW'(xi); wr_t = 24'(wr); wi_t = 24'(wi);
    in_valid = v; state = st; din_r = xr_t; din_i = xi_t; w_r = wr_t; w_i = wi_t;
    e.v = 1'b0; e.r = '0; e.i = '0;
    if (v) begin
      hr = m_r.pop_front(); hi = m_i.pop_front();
      pr = xr_t; pi = xi_t;
      case (st)
        2'd1: begin
          e.v = 1'b1;
          e.r = bf(longint'(hr) + longint'(xr_t));
          e.i = bf(longint'(hi) + longint'(xi_t));
          pr = bf(longint'(hr) - longint'(xr_t));
          pi = bf(longint'(hi) - longint'(xi_t));
        end
        2'd2: begin
          e.v = 1'b1;
          e.r = rnd(longint'(hr) * longint'(wr_t) - longint'(hi) * longint'(wi_t));
          e.i = rnd(longint'(hr) * longint'(wi_t) + longint'(hi) * longint'(wr_t));
        end
        2'd3: m_err = 1'b1;
        default: ;
      endcase
      m_r.push_back(pr); m_i.push_back(pi);
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("out_valid", out_valid, e.v);
    if (e.v) begin
      chk("dout_r", $signed(dout_r), $signed(e.r));
      chk("dout_i", $signed(dout_i), $signed(e.i));
      $display("out: st=%0d dout=(%0d,%0d) exp=(%0d,%0d)", st, $signed(dout_r), $signed(dout_i),
               $signed(e.r), $signed(e.i));
    end
    chk("err", err, m_err);
  endtask

  initial begin
    tbl[0] = '{2'd2, 100, 0, 0, 0, 0, -256, 0, -100};
    tbl[1] = '{2'd2, 1, 0, 0, 0, 181, -181, 1, -1};
    tbl[2] = '{2'd2, -3, 4, 9, 9, 256, 0, -3, 4};
    tbl[3] = '{2'd2, 1000, -1000, 0, 0, 128, 128, 1000, 0};
`ifdef SDF_SCALE_EN
    tbl[4] = '{2'd1, 32'h7FFFFF, 0, 1, 0, 0, 0, 32'h400000, 0};
    tbl[5] = '{2'd1, 5, -7, 3, 2, 0, 0, 4, -3};
    tbl[6] = '{2'd1, -8388608, 0, -1, 0, 0, 0, -4194305, 0};
`else
    tbl[4] = '{2'd1, 32'h7FFFFF, 0, 1, 0, 0, 0, -8388608, 0};
    tbl[5] = '{2'd1, 5, -7, 3, 2, 0, 0, 8, -5};
    tbl[6] = '{2'd1, -8388608, 0, -1, 0, 0, 0, 8388607, 0};
`endif

    rst = 1'b1; in_valid = 1'b0; state = 2'd0;
    din_r = '0; din_i = '0; w_r = '0; w_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Fill, butterfly, drain (drain refills with the next block's first half).
    for (int k = 0; k < DEPTH; k++) adv(1, 2'd0, k + 1, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) adv(1, 2'd1, 1000, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) adv(1, 2'd2, 2000 + k, -k, 256, 0);

    // Butterfly with a 5-cycle stall at k=20, then a rotating drain.
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 20) for (int s = 0; s < 5; s++) adv(0, 2'd1, 999, 999, 0, 0);
      adv(1, 2'd1, 300 - k, 7 * k, 0, 0);
    end
    for (int k = 0; k < DEPTH; k++) adv(1, 2'd2, k, k, 181, -181);

    // state=3 on idle cycles is ignored; on an advance it sets a sticky err and acts as fill.
    for (int k = 0; k < 5; k++) adv(0, 2'd3, 1, 1, 0, 0);
    adv(1, 2'd3, 55, 66, 0, 0);
    for (int k = 0; k < 100; k++) adv(0, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH - 1; k++) adv(1, 2'd0, k, 0, 0, 0);
    adv(1, 2'd1, 0, 0, 0, 0);
    chk("illegal_as_fill_r", $signed(dout_r), 55);
    chk("illegal_as_fill_i", $signed(dout_i), 66);
    do_reset();

    // Single-butterfly vectors with hand-computed results.
    for (int n = 0; n < 7; n++) begin
      do_reset();
      adv(1, 2'd0, tbl[n].hr, tbl[n].hi, 0, 0);
      for (int k = 0; k < DEPTH - 1; k++) adv(1, 2'd0, 0, 0, 0, 0);
      adv(1, tbl[n].st, tbl[n].xr, tbl[n].xi, tbl[n].wr, tbl[n].wi);
      chk("vec_dout_r", $signed(dout_r), tbl[n].er);
      chk("vec_dout_i", $signed(dout_i), tbl[n].ei);
      $display("vec %0d: dout=(%0d,%0d) exp=(%0d,%0d)", n, $signed(dout_r), $signed(dout_i),
               tbl[n].er, tbl[n].ei);
    end

    // Random traffic, then reset must clear the delay line.
    for (int k = 0; k < 80; k++)
      adv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
          int'($urandom_range(0, 32'hFFFFFF)) - 32'h800000,
          int'($urandom_range(0, 32'hFFFFFF)) - 32'h800000,
          int'($urandom_range(0, 512)) - 256, int'($urandom_range(0, 512)) - 256);
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      adv(1, 2'd1, 0, 0, 0, 0);
      chk("cleared_r", $signed(dout_r), 0);
      chk("cleared_i", $signed(dout_i), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/r2sdf_stage_64.md
Name: r2sdf_stage_64

Overview:
Radix-2 single-path delay-feedback (R2SDF) butterfly stage. It is the consumer of the 64-entry twiddle ROM's state/w_r/w_i interface in the 512-point FFT pipeline.
- Holds a DEPTH-deep complex delay line.
- Performs the add/subtract butterfly and the complex twiddle multiply.
- Emits one complex sample per advancing cycle to the next stage.

Parameters:
DW, 24, signed data width of each real/imag component
DEPTH, 64, delay-line length (half of the stage's butterfly span)
TW_FRAC, 8, twiddle fractional bits (256 = 1.0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input sample present; the stage advances only when high
din_r  input  DW  input sample, real part, signed
din_i  input  DW  input sample, imaginary part, signed
state  input  2  phase from twiddle ROM: 0=fill, 1=butterfly, 2=twiddle-drain, 3=illegal
w_r  input  24  twiddle real part, signed Q.TW_FRAC, same-cycle valid
w_i  input  24  twiddle imaginary part, signed Q.TW_FRAC, same-cycle valid
out_valid  output  1  dout valid
dout_r  output  DW  output sample, real part, signed
dout_i  output  DW  output sample, imaginary part, signed
err  output  1  sticky flag, set when state==3 is seen on an advancing cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - out_valid=0, dout_r=0, dout_i=0, err=0.
  - All delay-line entries cleared to 0.
  - Reset has priority over in_valid.
  - Reset mid-block discards the partial block; the system resets the twiddle ROM in the same cycle.
- Advance cycle: in_valid=1. Cycles with in_valid=0 hold the delay line and all state; out_valid=0 on the following cycle.
- Delay line: FIFO of DEPTH complex entries. Each advance cycle shifts it by exactly one: the head h (oldest entry) is consumed and one entry p is pushed.
- Per-advance operation, with x = (din_r, din_i):
  - state 0: p = x; no output (out_valid=0 next cycle).
  - state 1: output h + x; p = h - x.
  - state 2: output h * w; p = x.
  - state 3: behaves as state 0; err set to 1 and held until reset.
- Output timing: registered, latency 1. Results computed in advance cycle n appear with out_valid=1 in cycle n+1.
- Butterfly arithmetic:
  - Computed in DW+1 bits, then truncated to DW bits (two's-complement wrap).
  - No saturation.
- Complex multiply:
  - pr = hr*w_r - hi*w_i
  - pi = hr*w_i + hi*w_r
  - Full-precision products (DW+24 bits).
  - Add 2^(TW_FRAC-1), arithmetic shift right TW_FRAC (round-half-up), truncate to DW bits.
- Ordering:
  - `state` and `w` are sampled in the same cycle as din.
  - The stage makes no assumption about phase lengths; it obeys `state` every advance cycle.
  - The DEPTH alignment is the ROM's responsibility.
- Steady-state sequencing: 0×DEPTH once after reset, then alternating 1×DEPTH, 2×DEPTH. During state 2 the next block's first half fills the delay line.

Optional Feature:
SDF_SCALE_EN:
- Defined: butterfly sum and difference are computed in DW+1 bits, then arithmetic-shifted right by 1 (floor) before storing/outputting. This gives per-stage 1/2 scaling and never overflows.
- Undefined: no scaling; wrap as above. The multiply path is identical in both builds.

Test Plan:
- Reset: drive rst=1 for 1 cycle after arbitrary traffic -> next cycle out_valid=0, dout=0, err=0; a subsequent 64-cycle state-1 pass with x=0 outputs 0 (delay line cleared).
- Fill + butterfly: 64 advances, state 0, x=(k+1,0); then 64 advances, state 1, x=(1000,0) -> out_valid held 0 during fill; then dout_r=k+1001, dout_i=0 for k=0..63, each 1 cycle after its input.
- Drain: continue with 64 advances, state 2, w=(256,0) -> dout=(k+1-1000, 0); repeat a drain with h=(100,0), w=(0,-256) -> dout=(0,-100); h=(1,0), w=(181,-181) -> dout=(1,-1) (rounding check).
- Stall: drop in_valid for 5 cycles at k=20 of the butterfly phase -> out_valid=0 for those 5 cycles, no shift; k=20..63 outputs unchanged vs. the no-stall run.
- Overflow: h=(0x7FFFFF,0), x=(1,0), state 1 -> dout_r=0x800000 without SDF_SCALE_EN; 0x400000 with it.
- Illegal state: one advance with state=3 -> err=1 and stays 1 for 100 cycles; the entry behaves as fill; rst clears err.
